// File: rtl/flash_sched_pkg.sv
// ============================================================================
// flash_sched_pkg : shared types, reset defaults and length clamp for flash_sched
// Revision: 1.0
// ============================================================================
`default_nettype none

package flash_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } chan_state_e;

  localparam int unsigned C_DEF_ON_LEN  = 1;
  localparam int unsigned C_DEF_OFF_LEN = 1;
  localparam int unsigned C_DEF_REPS    = 0;

  // A programmed length of zero behaves as one tick so a phase never stalls.
  function automatic logic [31:0] len_clamp(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flash_sched_if.sv
// ============================================================================
// flash_sched_if : tick, config and command bus plus per-channel status outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface flash_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 6,
  parameter int RW  = 4
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           tick_in;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_on;
  logic [CW-1:0]  cfg_off;
  logic [RW-1:0]  cfg_reps;
  logic           cmd_start;
  logic           cmd_stop;
  logic [CHW-1:0] cmd_ch;
  logic [NCH-1:0] flash_on;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;

  modport master (
    output tick_in, cfg_we, cfg_ch, cfg_on, cfg_off, cfg_reps,
    output cmd_start, cmd_stop, cmd_ch,
    input  flash_on, busy, done
  );

  modport slave (
    input  tick_in, cfg_we, cfg_ch, cfg_on, cfg_off, cfg_reps,
    input  cmd_start, cmd_stop, cmd_ch,
    output flash_on, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/flash_chan.sv
// ============================================================================
// flash_chan : one blink channel - config regs, ON/OFF phase FSM, repeat counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module flash_chan
  import flash_sched_pkg::*;
#(
  parameter int CW = 6,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_i,
  input  logic          ld_cfg_i,
  input  logic [CW-1:0] cfg_on_i,
  input  logic [CW-1:0] cfg_off_i,
  input  logic [RW-1:0] cfg_reps_i,
  input  logic          start_i,
  input  logic          stop_i,
  output logic          flash_on_o,
  output logic          busy_o,
  output logic          done_o
);

  chan_state_e   state_q;
  logic [CW-1:0] on_len_q;
  logic [CW-1:0] off_len_q;
  logic [RW-1:0] reps_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] rcnt_q;
  logic          flash_on_q;
  logic          busy_q;
  logic          done_q;

  // A config write coinciding with a load is seen by that load.
  logic [CW-1:0] w_on_len;
  logic [CW-1:0] w_off_len;
  logic [RW-1:0] w_reps;

  assign w_on_len  = ld_cfg_i ? cfg_on_i   : on_len_q;
  assign w_off_len = ld_cfg_i ? cfg_off_i  : off_len_q;
  assign w_reps    = ld_cfg_i ? cfg_reps_i : reps_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      on_len_q   <= CW'(C_DEF_ON_LEN);
      off_len_q  <= CW'(C_DEF_OFF_LEN);
      reps_q     <= RW'(C_DEF_REPS);
      cnt_q      <= '0;
      rcnt_q     <= '0;
      flash_on_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ld_cfg_i) begin
        on_len_q  <= cfg_on_i;
        off_len_q <= cfg_off_i;
        reps_q    <= cfg_reps_i;
      end

      if (stop_i) begin
        state_q    <= ST_IDLE;
        flash_on_q <= 1'b0;
        busy_q     <= 1'b0;
      end else if (start_i) begin
        state_q    <= ST_ON;
        cnt_q      <= CW'(len_clamp(32'(w_on_len)));
        rcnt_q     <= w_reps;
        flash_on_q <= 1'b1;
        busy_q     <= 1'b1;
      end else if (tick_i) begin
        case (state_q)
          ST_ON: begin
            if (cnt_q == CW'(1)) begin
              state_q    <= ST_OFF;
              cnt_q      <= CW'(len_clamp(32'(w_off_len)));
              flash_on_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_OFF: begin
            if (cnt_q != CW'(1)) begin
              cnt_q <= cnt_q - CW'(1);
            end else if (rcnt_q == RW'(1)) begin
              // rcnt of zero means continuous, so only a finite run reaches here
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              if (rcnt_q != '0) begin
                rcnt_q <= rcnt_q - RW'(1);
              end
              state_q    <= ST_ON;
              cnt_q      <= CW'(len_clamp(32'(w_on_len)));
              flash_on_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign flash_on_o = flash_on_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

`default_nettype wire

// File: rtl/flash_sched.sv
// ============================================================================
// flash_sched : NCH independent blink channels sharing one slow tick
// Revision: 1.0
// ============================================================================
`default_nettype none

module flash_sched
  import flash_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 6,
  parameter int RW  = 4
) (
  input logic         clk,
  input logic         reset,
  flash_sched_if.slave bus
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] w_flash_on;
  logic [NCH-1:0] w_busy;
  logic [NCH-1:0] w_done;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic w_ld_cfg;
    logic w_start;
    logic w_stop;

    assign w_ld_cfg = bus.cfg_we    && (bus.cfg_ch == CHW'(gi));
    assign w_start  = bus.cmd_start && (bus.cmd_ch == CHW'(gi));
    assign w_stop   = bus.cmd_stop  && (bus.cmd_ch == CHW'(gi));

    flash_chan #(
      .CW (CW),
      .RW (RW)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .tick_i     (bus.tick_in),
      .ld_cfg_i   (w_ld_cfg),
      .cfg_on_i   (bus.cfg_on),
      .cfg_off_i  (bus.cfg_off),
      .cfg_reps_i (bus.cfg_reps),
      .start_i    (w_start),
      .stop_i     (w_stop),
      .flash_on_o (w_flash_on[gi]),
      .busy_o     (w_busy[gi]),
      .done_o     (w_done[gi])
    );
  end

  assign bus.flash_on = w_flash_on;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;

endmodule

`default_nettype wire

// File: doc/flash_sched.md
Name: flash_sched

Overview:
- Multi-channel blink scheduler that shares one slow periodic tick (the 1-cycle enable pulse from the flash clock divider) among NCH independent flash requesters.
- Typical requesters: text cursor, blinking attribute, alarm region.
- Each channel has a programmable ON length, OFF length and repeat count, all measured in ticks.
- Each channel drives a registered flash_on level consumed by the VGA pixel path.

Parameters:
- NCH, 4, number of flash channels (2..8)
- CW, 6, width of ON/OFF tick-length fields
- RW, 4, width of repeat-count field (0 = continuous)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_in  in  1  1-cycle base tick from the divider; may be high for consecutive cycles
- cfg_we  in  1  config write strobe
- cfg_ch  in  clog2(NCH)  channel addressed by the config write
- cfg_on  in  CW  ON length in ticks (0 treated as 1)
- cfg_off  in  CW  OFF length in ticks (0 treated as 1)
- cfg_reps  in  RW  number of ON/OFF cycles; 0 = run until stopped
- cmd_start  in  1  start strobe for cmd_ch
- cmd_stop  in  1  stop strobe for cmd_ch
- cmd_ch  in  clog2(NCH)  channel addressed by the command
- flash_on  out  NCH  per-channel blink level (registered)
- busy  out  NCH  channel is in ON or OFF
- done  out  NCH  1-cycle pulse when a finite sequence completes

Behaviour:
- Reset:
  - All channels IDLE.
  - flash_on=0, busy=0, done=0.
  - Config regs: on_len=1, off_len=1, reps=0.
  - Phase counters and repeat counters = 0.
- Config:
  - cfg_we writes on_len/off_len/reps of cfg_ch at the clock edge.
  - A write while the channel is busy takes effect at the next phase load; the current phase count is unaffected.
- Per-channel FSM states: IDLE, ON, OFF.
- IDLE:
  - On start → ON next cycle.
  - Load cnt=max(on_len,1) and rcnt=reps.
  - flash_on=1 and busy=1 from the following cycle.
- ON:
  - On tick_in, if cnt==1 → OFF, cnt=max(off_len,1), flash_on=0.
  - On tick_in otherwise → cnt-1.
- OFF, on tick_in with cnt==1:
  - If reps==0 (latched at start) → ON, reload on_len.
  - Else if rcnt==1 → IDLE, busy=0, done pulse for 1 cycle.
  - Else → rcnt-1, ON, reload on_len.
- OFF, on tick_in with cnt>1: cnt-1.
- Latency:
  - All outputs are registered.
  - A phase change is visible the cycle after the tick edge that completes it.
- Stop:
  - Channel → IDLE next cycle, flash_on=0, busy=0.
  - No done pulse.
  - Stop in IDLE has no effect.
- Start while busy: restart from ON with fresh counts; no done pulse.
- Simultaneous events:
  - start and stop on the same cycle: stop wins.
  - start and tick_in on the same cycle: the start load occurs and the tick is ignored for that channel.
  - cfg_we and start on the same channel in the same cycle: start loads the NEW config values.
- Channels are fully independent; one tick_in advances every busy channel in the same cycle.
- Counters never wrap: cnt stops at 1 awaiting a tick, and 0 is never loaded.
- Reset mid-sequence:
  - Immediate return to IDLE with all outputs 0.
  - Config returns to defaults.

Decomposition:
- Package flash_sched_pkg holds:
  - the state enum (IDLE/ON/OFF, 2-bit),
  - the default config constants,
  - a helper for the zero-to-one length clamp.
- Sub-module flash_chan: one channel FSM with counters.
  - Ports: clk, reset, tick, ld_cfg, cfg fields, start, stop, flash_on, busy, done.
  - Top decodes cfg_ch/cmd_ch and instantiates NCH copies via generate.

Test Plan:
- Reset then idle 100 cycles with ticks → flash_on=0, busy=0, done=0 on all channels.
- ch0 cfg on=2, off=3, reps=2, start, tick every 4 cycles → flash_on pattern 1,1,0,0,0,1,1,0,0,0 (in ticks), then done[0] for 1 cycle and busy[0]=0.
- ch1 cfg on=0, off=0, reps=0, tick every cycle → flash_on toggles each cycle indefinitely; stop → 0 next cycle and no done.
- start+stop same cycle on ch2 → stays IDLE. start with tick_in high the same cycle → first ON lasts a full on_len ticks.
- ch3 running on=5, cfg_we on=1 mid-ON → current ON still 5 ticks, the next ON is 1 tick.
- Reset asserted mid-OFF on ch0 with ch1 active → all outputs 0 immediately, and after release start ch0 uses defaults (1/1/continuous).
